// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit: state encodings, opcodes, ALU classes, datapath control word.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_FETCH  = 4'd0,
      ST_DECODE = 4'd1,
      ST_MEMADR = 4'd2,
      ST_MEMRD  = 4'd3,
      ST_MEMWB  = 4'd4,
      ST_MEMWR  = 4'd5,
      ST_EXEC_R = 4'd6,
      ST_RWB    = 4'd7,
      ST_EXEC_I = 4'd8,
      ST_IWB    = 4'd9,
      ST_BRANCH = 4'd10,
      ST_HALT   = 4'd11,
      ST_JUMP   = 4'd12
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_BGTZ  = 6'b000111;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;
   localparam logic [1:0] ALU_IMM   = 2'b11;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
   } ctl_t;

   // ALU class for the I-type ops; addi is a plain add, the others need the immediate-op class.
   function automatic logic [1:0] imm_alu_class(input logic [5:0] op);
      logic [1:0] cls;
      cls = ALU_ADD;
      if (op == OP_SLTI || op == OP_ANDI || op == OP_ORI) cls = ALU_IMM;
      return cls;
   endfunction

   // Per-state control word. FETCH reports pc_write/ir_write as "armed"; the top gates them with MemReady.
   function automatic ctl_t ctl_decode(input state_e st, input logic [1:0] imm_cls);
      ctl_t c;
      c = '0;
      case (st)
         ST_FETCH: begin
            c.mem_read  = 1'b1;
            c.ir_write  = 1'b1;
            c.pc_write  = 1'b1;
            c.alu_src_b = 2'b01;
         end
         ST_DECODE: c.alu_src_b = 2'b11;
         ST_MEMADR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
         end
         ST_MEMRD: begin
            c.mem_read = 1'b1;
            c.i_or_d   = 1'b1;
         end
         ST_MEMWB: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
         end
         ST_MEMWR: begin
            c.mem_write = 1'b1;
            c.i_or_d    = 1'b1;
         end
         ST_EXEC_R: begin
            c.alu_src_a = 1'b1;
            c.alu_op    = ALU_FUNCT;
         end
         ST_RWB: begin
            c.reg_write = 1'b1;
            c.reg_dst   = 1'b1;
         end
         ST_EXEC_I: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
            c.alu_op    = imm_cls;
         end
         ST_IWB: c.reg_write = 1'b1;
         ST_BRANCH: begin
            c.alu_src_a     = 1'b1;
            c.alu_op        = ALU_SUB;
            c.pc_write_cond = 1'b1;
            c.pc_source     = 2'b01;
         end
         ST_JUMP: begin
            c.pc_write  = 1'b1;
            c.pc_source = 2'b10;
         end
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/wait_counter.sv
// Saturating wait-cycle counter for memory handshakes; done flags the cycle in which the count reaches WAIT_LIMIT.
// Latency: done is combinational from the current count and en; count updates on the next clk edge.
// Backpressure: none; clr has priority over en.
// Ports: clk, rst_n (async active-low), clr (restart at 0), en (count this cycle), done (limit reached this cycle).
module wait_counter #(
   parameter int WAIT_LIMIT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic done
);

   localparam int CW = $clog2(WAIT_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(WAIT_LIMIT);
   localparam logic [CW-1:0] LAST  = CW'(WAIT_LIMIT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // The counter holds the number of waits already seen, so the edge that would make it WAIT_LIMIT is the timeout edge.
   assign done = en && (cnt_q >= LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clr)                        cnt_d = '0;
      else if (en && cnt_q != LIMIT)  cnt_d = cnt_q + CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a multicycle MIPS datapath with memory wait timeout and illegal-opcode detection.
// Latency: one state per clk; FETCH/MEMRD/MEMWR stall until MemReady, HALT after WAIT_LIMIT unanswered cycles.
// Backpressure: MemReady gates leaving the memory states; HALT is left only through rst_n.
// Ports: clk, rst_n; Op (sampled in DECODE), MemReady; datapath enables/selects; State (debug); IllegalOp, Timeout.
// Build option: define JUMP_EN to decode Op 000010 as a jump; otherwise it is treated as illegal.
module multicycle_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int WAIT_LIMIT = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] Op,
   input  logic       MemReady,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemToWrite,
   output logic       IRWrite,
   output logic       MemToReg,
   output logic       RegDst,
   output logic       RegToWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] AluOp,
   output logic [1:0] PCSource,
   output logic [3:0] State,
   output logic       IllegalOp,
   output logic       Timeout
);

   state_e     state_q, state_d;
   logic [5:0] op_q, op_d;
   logic       illegal_q, illegal_d;
   logic       timeout_q, timeout_d;
   logic       cnt_en, cnt_clr, wait_done;
   ctl_t       ctl;

   // Counting only while a memory state is stalled; any state change restarts the count.
   assign cnt_en  = (state_q == ST_FETCH || state_q == ST_MEMRD || state_q == ST_MEMWR) && !MemReady;
   assign cnt_clr = (state_d != state_q);

   wait_counter #(.WAIT_LIMIT(WAIT_LIMIT)) u_wait (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .done  (wait_done)
   );

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      illegal_d = 1'b0;
      case (state_q)
         ST_FETCH: begin
            if (MemReady)       state_d = ST_DECODE;
            else if (wait_done) state_d = ST_HALT;
         end
         ST_DECODE: begin
            op_d = Op;
            case (Op)
               OP_RTYPE:                   state_d = ST_EXEC_R;
               OP_LW, OP_SW:               state_d = ST_MEMADR;
               OP_ADDI, OP_SLTI,
               OP_ANDI, OP_ORI:            state_d = ST_EXEC_I;
               OP_BEQ, OP_BNE, OP_BGTZ:    state_d = ST_BRANCH;
`ifdef JUMP_EN
               OP_J:                       state_d = ST_JUMP;
`endif
               default: begin
                  state_d   = ST_FETCH;
                  illegal_d = 1'b1;
               end
            endcase
         end
         ST_MEMADR: state_d = (op_q == OP_SW) ? ST_MEMWR : ST_MEMRD;
         ST_MEMRD: begin
            if (MemReady)       state_d = ST_MEMWB;
            else if (wait_done) state_d = ST_HALT;
         end
         ST_MEMWR: begin
            if (MemReady)       state_d = ST_FETCH;
            else if (wait_done) state_d = ST_HALT;
         end
         ST_EXEC_R: state_d = ST_RWB;
         ST_EXEC_I: state_d = ST_IWB;
         ST_HALT:   state_d = ST_HALT;
         default:   state_d = ST_FETCH;
      endcase
      timeout_d = (state_d == ST_HALT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_FETCH;
         op_q      <= '0;
         illegal_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         illegal_q <= illegal_d;
         timeout_q <= timeout_d;
      end
   end

   // FETCH only commits the instruction and PC in the cycle memory answers.
   // Forcing the word to zero under reset keeps MemRead quiet while state already reads FETCH.
   always_comb begin
      ctl = ctl_decode(state_q, imm_alu_class(op_q));
      if (state_q == ST_FETCH) begin
         ctl.pc_write = MemReady;
         ctl.ir_write = MemReady;
      end
      if (!rst_n) ctl = '0;
   end

   assign PCWrite     = ctl.pc_write;
   assign PCWriteCond = ctl.pc_write_cond;
   assign IorD        = ctl.i_or_d;
   assign MemRead     = ctl.mem_read;
   assign MemToWrite  = ctl.mem_write;
   assign IRWrite     = ctl.ir_write;
   assign MemToReg    = ctl.mem_to_reg;
   assign RegDst      = ctl.reg_dst;
   assign RegToWrite  = ctl.reg_write;
   assign ALUSrcA     = ctl.alu_src_a;
   assign ALUSrcB     = ctl.alu_src_b;
   assign AluOp       = ctl.alu_op;
   assign PCSource    = ctl.pc_source;
   assign State       = state_q;
   assign IllegalOp   = illegal_q;
   assign Timeout     = timeout_q;

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 15: max memory wait cycles before timeout.
REQ-002 SHALL have port clk, input, 1: the single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port Op, input, 6: opcode, sampled only in DECODE.
REQ-005 SHALL have port MemReady, input, 1: memory access complete this cycle.
REQ-006 SHALL have ports PCWrite, PCWriteCond, IorD, MemRead, MemToWrite, IRWrite, MemToReg, RegDst, RegToWrite, ALUSrcA; each output, 1: datapath enables and mux selects.
REQ-007 SHALL have ports ALUSrcB, AluOp and PCSource; each output, 2: mux selects and ALU class.
REQ-008 SHALL have port State, output, 4: current state encoding, for debug.
REQ-009 SHALL have ports IllegalOp and Timeout, output, 1: error flags.

Function
REQ-010 SHALL be a Moore FSM; all outputs decode from the registered state only, except MemReady gating of transitions.
REQ-011 SHALL use states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, RWB, EXEC_I, IWB, BRANCH, HALT, plus JUMP when configured.
REQ-012 SHALL hold FETCH asserting MemRead, IRWrite, PCWrite, ALUSrcB=01, AluOp=00, PCSource=00 with IorD=0; IRWrite and PCWrite assert only in the cycle MemReady=1; that cycle moves to DECODE.
REQ-013 SHALL in DECODE drive ALUSrcA=0, ALUSrcB=11, AluOp=00 and branch on Op: 000000 to EXEC_R; 100011 and 101011 to MEMADR; 001000 to EXEC_I with AluOp class 00; 001010, 001100 and 001101 to EXEC_I with AluOp class 11; 000100, 000101 and 000111 to BRANCH.
REQ-014 SHALL on any other Op in DECODE pulse IllegalOp for one cycle and return to FETCH with no register or memory write.
REQ-015 SHALL drive MEMADR with ALUSrcA=1, ALUSrcB=10, AluOp=00, then go to MEMRD for LW or to MEMWR for SW.
REQ-016 SHALL drive MEMRD with MemRead=1 and IorD=1, and stay there until MemReady, then go to MEMWB.
REQ-017 SHALL drive MEMWB with RegToWrite=1, MemToReg=1, RegDst=0, then return to FETCH.
REQ-018 SHALL drive MEMWR with MemToWrite=1 and IorD=1, and stay there until MemReady, then return to FETCH.
REQ-019 SHALL drive EXEC_R with ALUSrcA=1, ALUSrcB=00, AluOp=10, then go to RWB; RWB drives RegToWrite=1, RegDst=1, then returns to FETCH.
REQ-020 SHALL drive EXEC_I with ALUSrcA=1, ALUSrcB=10 and the latched AluOp class, then go to IWB; IWB drives RegToWrite=1, RegDst=0, MemToReg=0, then returns to FETCH.
REQ-021 SHALL drive BRANCH with ALUSrcA=1, ALUSrcB=00, AluOp=01, PCWriteCond=1, PCSource=01, then return to FETCH.
REQ-022 SHALL latch Op (or the derived class) in DECODE; later states use the latched value, not the live Op input.
REQ-023 SHALL count wait cycles in FETCH, MEMRD and MEMWR with a saturating counter cleared on each state entry; if the counter reaches WAIT_LIMIT without MemReady, it goes to HALT.
REQ-024 SHALL in HALT hold Timeout=1 with all write/enables at 0, and remain there until reset.
REQ-025 SHALL drive every signal not named for a state to 0.

Reset
REQ-026 SHALL on rst_n=0 immediately set state FETCH, clear the wait counter, latched Op and both error flags; all enables read 0 while reset is asserted.
REQ-027 SHALL when reset asserts mid-access abandon the access; no write enable asserts after reset deassertion until an instruction reaches its write state.

Configuration
REQ-028 SHALL with JUMP_EN defined decode Op 000010 to state JUMP (PCWrite=1, PCSource=10, then FETCH); without JUMP_EN, 000010 is illegal per REQ-014.

Structure
REQ-029 SHALL place state encodings, opcode constants and AluOp class constants in shared package mips_ctrl_pkg.
REQ-030 SHALL implement the wait counter as sub-module wait_counter (clear, enable, saturate at WAIT_LIMIT, done flag).

Verification
REQ-031 SHALL cover R-type: Op=000000 with MemReady=1 in fetch -> FETCH, DECODE, EXEC_R (AluOp=10), RWB (RegToWrite=1, RegDst=1), FETCH; 4 cycles.
REQ-032 SHALL cover LW with 3 wait cycles: Op=100011 with MemReady low 3 cycles in MEMRD -> MEMRD held 4 cycles, then MEMWB with MemToReg=1.
REQ-033 SHALL cover illegal op: Op=111111 -> IllegalOp high exactly 1 cycle, no RegToWrite or MemToWrite, next state FETCH.
REQ-034 SHALL cover timeout: MemReady held 0 in FETCH for 15 cycles -> HALT with Timeout=1; rst_n pulse returns to FETCH.
REQ-035 SHALL cover reset in MEMWR: rst_n=0 while MemToWrite=1 -> MemToWrite falls asynchronously and state reads FETCH.
REQ-036 SHALL cover JUMP_EN both ways: Op=000010 -> JUMP with PCSource=10 when defined, IllegalOp pulse when undefined.
